// File: rtl/cordic_phase_sequencer_if.sv
// Handshake bundle between the phase sequencer, its phase source, the CORDIC
// core and the downstream consumer of the quadrant-corrected result.
interface cordic_phase_sequencer_if #(
  parameter int PHASE_W = 14
);
  logic               phase_valid;
  logic               phase_ready;
  logic [PHASE_W-1:0] phase;
  logic               core_start;
  logic [PHASE_W-3:0] core_angle;
  logic               core_done;
  logic [1:0]         sel_quarter;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               timeout_err;
  logic [15:0]        done_count;

  modport slave (
    input  phase_valid, phase, core_done, out_ready,
    output phase_ready, core_start, core_angle, sel_quarter,
           out_valid, busy, timeout_err, done_count
  );

  modport master (
    output phase_valid, phase, core_done, out_ready,
    input  phase_ready, core_start, core_angle, sel_quarter,
           out_valid, busy, timeout_err, done_count
  );
endinterface

// File: rtl/cordic_phase_sequencer.sv
// Front-end controller for the iterative CORDIC: folds a full-turn phase into
// quadrant + first-quadrant angle, launches the core and strobes the result.
module cordic_phase_sequencer #(
  parameter int PHASE_W        = 14,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  cordic_phase_sequencer_if.slave  bus
);

  localparam int ANGLE_W = PHASE_W - 2;
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SELECT,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [ANGLE_W-1:0] core_angle_q, core_angle_d;
  logic [1:0]         sel_quarter_q, sel_quarter_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               timeout_err_q, timeout_err_d;
  logic [15:0]        done_count_q, done_count_d;
  logic               phase_ready_q, phase_ready_d;
  logic               core_start_q, core_start_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [1:0]         in_quarter;
  logic [ANGLE_W-1:0] in_angle;

  assign in_quarter = bus.phase[PHASE_W-1:PHASE_W-2];
  assign in_angle   = bus.phase[ANGLE_W-1:0];

  // Odd quadrants run the core on the mirrored angle so it only ever sees 0..90 deg.
  always_comb begin
    state_d       = state_q;
    core_angle_d  = core_angle_q;
    sel_quarter_d = sel_quarter_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    done_count_d  = done_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.phase_valid) begin
          sel_quarter_d = in_quarter;
          core_angle_d  = in_quarter[0] ? ~in_angle : in_angle;
          state_d       = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.core_done) begin
          state_d = ST_SELECT;
        end else if (wdog_q == WDOG_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_SELECT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    phase_ready_d = (state_d == ST_IDLE);
    core_start_d  = (state_d == ST_LAUNCH);
    out_valid_d   = (state_d == ST_HOLD);
    busy_d        = (state_d != ST_IDLE);
  end

  // Handshake outputs are decoded from the next state so they appear registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      core_angle_q  <= '0;
      sel_quarter_q <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      done_count_q  <= '0;
      phase_ready_q <= 1'b1;
      core_start_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_angle_q  <= core_angle_d;
      sel_quarter_q <= sel_quarter_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      done_count_q  <= done_count_d;
      phase_ready_q <= phase_ready_d;
      core_start_q  <= core_start_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.phase_ready = phase_ready_q;
  assign bus.core_start  = core_start_q;
  assign bus.core_angle  = core_angle_q;
  assign bus.sel_quarter = sel_quarter_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.done_count  = done_count_q;

endmodule

// File: doc/cordic_phase_sequencer.md
Name: cordic_phase_sequencer

Overview:
- Front-end controller for the iterative sine/cosine CORDIC datapath.
- Accepts a full-circle phase word and splits it into quadrant and in-quadrant angle; mirrors the angle in odd quadrants.
- Launches the CORDIC core with a start/done handshake, holds the quadrant select stable for the quadrant-correction stage, and allows one pipeline cycle for that stage's register.
- Presents a valid/ready result strobe, guarded by a watchdog on the core.

Parameters:
- PHASE_W, 14, phase input width: bits [PHASE_W-1:PHASE_W-2] are the quadrant, the remaining bits are the angle.
- TIMEOUT_CYCLES, 32, maximum cycles in WAIT before the core is declared hung (must be ≥1).
- CNT_W, 6, width of the watchdog counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- phase_valid  input  1  phase word offered
- phase_ready  output  1  sequencer can accept phase
- phase  input  PHASE_W  phase word, 0..2^PHASE_W-1 = one full turn
- core_start  output  1  one-cycle launch pulse to the CORDIC core
- core_angle  output  PHASE_W-2  angle to the CORDIC core
- core_done  input  1  core finished (single-cycle pulse)
- sel_quarter  output  2  quadrant select to the quadrant-correction stage
- out_valid  output  1  corrected X/Y available downstream
- out_ready  input  1  downstream accepts result
- busy  output  1  high in any state except IDLE
- timeout_err  output  1  sticky watchdog flag
- done_count  output  16  completed-result counter, wraps

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, core_start=0, core_angle=0, sel_quarter=0.
  - out_valid=0, busy=0, timeout_err=0, done_count=0, watchdog=0.
  - phase_ready=1 from the first cycle after reset release.
- Reset mid-operation aborts everything. No out_valid and no core_start are issued for the aborted phase. Any later core_done is ignored, because it arrives outside WAIT.
- States and transitions:
  - IDLE: phase_ready=1. On phase_valid&&phase_ready:
    - latch q=phase[PHASE_W-1:PHASE_W-2] into sel_quarter;
    - latch a=phase[PHASE_W-3:0] into core_angle, but if q[0]=1 latch ~a (bitwise complement, i.e. 2^(PHASE_W-2)-1-a);
    - go to LAUNCH.
  - phase_ready is 0 in all other states.
  - LAUNCH: core_start=1 for exactly this cycle; watchdog cleared; go to WAIT.
  - WAIT: watchdog increments each cycle.
    - core_done=1 → SELECT.
    - Else, watchdog==TIMEOUT_CYCLES-1 → timeout_err<=1, go to IDLE, no result.
    - core_done on the same cycle as the limit: done wins (SELECT, no error).
  - SELECT: one cycle for the quadrant-correction register to capture; go to HOLD.
  - HOLD: out_valid=1 until out_ready=1. On acceptance:
    - done_count<=done_count+1 (16-bit wrap, 0xFFFF→0x0000);
    - go to IDLE.
  - out_valid deasserts the cycle after acceptance. out_ready is ignored outside HOLD.
- Held values:
  - sel_quarter and core_angle stay constant from the latch cycle until the next accepted phase, including through HOLD back-pressure.
  - timeout_err clears only on reset.
- Latency: phase accepted at cycle 0 → core_start at cycle 1 → core_done at cycle k → out_valid at cycle k+2. Minimum phase-to-phase interval is k+3 cycles with out_ready held high.
- core_done in IDLE, LAUNCH, SELECT or HOLD is ignored.

Test Plan:
- Reset, then phase=0x0123 valid. Expect: phase_ready drops the next cycle; sel_quarter=0, core_angle=0x123; core_start pulses one cycle later. With core_done 10 cycles after core_start, out_valid rises 2 cycles after done. With out_ready=1, done_count=1.
- phase=0x1800. Expect sel_quarter=1, core_angle=0x7FF. phase=0x3FFF → sel_quarter=3, core_angle=0x000. phase=0x2ABC → sel_quarter=2, core_angle=0xABC.
- out_ready held 0 for 20 cycles in HOLD. Expect: out_valid stays 1, sel_quarter/core_angle stable, phase_ready=0, extra phase_valid not accepted. Then out_ready=1 → one count, back to IDLE.
- core_done withheld. Expect: timeout_err=1 exactly 32 cycles after entering WAIT; no out_valid; phase_ready=1 next; flag stays set across later good transactions. Second case: core_done on the 32nd WAIT cycle → normal result, timeout_err stays 0.
- rst=0 asserted during WAIT, then core_done pulsed after release. Expect: all outputs at reset values, no out_valid, done_count=0.
- Preload 0xFFFF completions (or force done_count). Next acceptance → done_count=0x0000. Stray core_done pulses in IDLE/HOLD cause no state change.
